// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic [1:0] {W_BYTE, W_HALF, W_WORD, W_DWORD} width_t;

    localparam int BYTE_BITS  = 8;
    localparam int HALF_BITS  = 16;
    localparam int WORD_BITS  = 32;
    localparam int DWORD_BITS = 64;

    // Mask of the destination bits a write of the given width replaces.
    function automatic logic [DWORD_BITS-1:0] width_mask(input width_t w);
        logic [DWORD_BITS-1:0] m;
        m = '1;
        case (w)
            W_BYTE:  m = (64'd1 << BYTE_BITS) - 64'd1;
            W_HALF:  m = (64'd1 << HALF_BITS) - 64'd1;
            W_WORD:  m = (64'd1 << WORD_BITS) - 64'd1;
            W_DWORD: m = '1;
            default: m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/regfile_merge.sv
// Combinational sub-width merge: low bits from din, upper bits preserved from old.
module regfile_merge
    import regfile_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] old,
    input  width_t          width,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] merged
);

    logic [DWORD_BITS-1:0] w_mask64;
    logic [XLEN-1:0]       w_mask;

    // With XLEN=32 the truncated word and dword masks are both all-ones.
    assign w_mask64 = width_mask(width);
    assign w_mask   = w_mask64[XLEN-1:0];
    assign merged   = (old & ~w_mask) | (din & w_mask);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREGS    = 16,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [AW-1:0]       wrsel,
    input  logic [1:0]          width,
    input  logic [XLEN-1:0]     din,
    input  logic                claim,
    input  logic [AW-1:0]       claimsel,
    input  logic [NRD*AW-1:0]   rdsel,
    output logic [NRD*XLEN-1:0] rdout,
    output logic [NRD-1:0]      rdbusy,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic             w_wr_en;
    logic             w_claim_en;
    logic [XLEN-1:0]  w_merged;
    logic [NREGS-1:0] w_busy_next;

    // r0 writes and claims are dropped entirely when it is hardwired to zero.
    assign w_wr_en    = wr    && !((ZERO_REG != 0) && (wrsel    == '0));
    assign w_claim_en = claim && !((ZERO_REG != 0) && (claimsel == '0));

    regfile_merge #(.XLEN(XLEN)) u_merge (
        .old    (r_regs[wrsel]),
        .width  (width_t'(width)),
        .din    (din),
        .merged (w_merged)
    );

    // Claim is applied after the write clear so a same-cycle new producer wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_en)    w_busy_next[wrsel]    = 1'b0;
        if (w_claim_en) w_busy_next[claimsel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_en) r_regs[wrsel] <= w_merged;
            r_busy <= w_busy_next;
        end
    end

    assign busy_vec = r_busy;

    always_comb begin
        logic [AW-1:0] w_sel;
        w_sel  = '0;
        rdout  = '0;
        rdbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            w_sel = rdsel[i*AW +: AW];
            if ((ZERO_REG != 0) && (w_sel == '0)) begin
                rdout[i*XLEN +: XLEN] = '0;
                rdbusy[i]             = 1'b0;
            end else begin
                rdout[i*XLEN +: XLEN] = r_regs[w_sel];
                rdbusy[i]             = r_busy[w_sel];
            end
`ifdef REGFILE_BYPASS_EN
            if (w_wr_en && (w_sel == wrsel)) begin
                rdout[i*XLEN +: XLEN] = w_merged;
                rdbusy[i]             = w_claim_en && (claimsel == wrsel);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (NRD=4, ZERO_REG=1, 16x64).
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 16;
    localparam int NRD   = 4;
    localparam int AW    = 4;

    logic                clk;
    logic                reset;
    logic                wr;
    logic [AW-1:0]       wrsel;
    logic [1:0]          width;
    logic [XLEN-1:0]     din;
    logic                claim;
    logic [AW-1:0]       claimsel;
    logic [NRD*AW-1:0]   rdsel;
    logic [NRD*XLEN-1:0] rdout;
    logic [NRD-1:0]      rdbusy;
    logic [NREGS-1:0]    busy_vec;

    int total;
    int bad;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .wrsel    (wrsel),
        .width    (width),
        .din      (din),
        .claim    (claim),
        .claimsel (claimsel),
        .rdsel    (rdsel),
        .rdout    (rdout),
        .rdbusy   (rdbusy),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] sel);
        rdsel[p*AW +: AW] = sel;
        #1;
    endtask

    function automatic logic [63:0] rd(input int p);
        return rdout[p*XLEN +: XLEN];
    endfunction

    task automatic do_write(input logic [AW-1:0] sel, input logic [1:0] w, input logic [63:0] d);
        wr = 1'b1; wrsel = sel; width = w; din = d;
        tick();
        wr = 1'b0;
        #1;
    endtask

    task automatic do_claim(input logic [AW-1:0] sel);
        claim = 1'b1; claimsel = sel;
        tick();
        claim = 1'b0;
        #1;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; wr = 1'b0; wrsel = '0; width = 2'd3; din = '0;
        claim = 1'b0; claimsel = '0; rdsel = '0;
        tick();
        reset = 1'b0;

        // 1. reset after prior writes and claims
        do_write(4'd4, 2'd3, 64'hAAAA_BBBB_CCCC_DDDD);
        do_claim(4'd6);
        set_rd(0, 4'd4); set_rd(1, 4'd6);
        chk("pre_reset_r4", rd(0), 64'hAAAA_BBBB_CCCC_DDDD);
        chk("pre_reset_busy", {48'd0, busy_vec}, 64'h0040);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("reset_r4", rd(0), 64'h0);
        chk("reset_r6", rd(1), 64'h0);
        chk("reset_busy_vec", {48'd0, busy_vec}, 64'h0);
        chk("reset_rdbusy", {60'd0, rdbusy}, 64'h0);

        // 2. sub-width merges into r3
        set_rd(0, 4'd3);
        do_write(4'd3, 2'd3, 64'h1122_3344_5566_7788);
        chk("dword_r3", rd(0), 64'h1122_3344_5566_7788);
        do_write(4'd3, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("byte_merge", rd(0), 64'h1122_3344_5566_77FF);
        do_write(4'd3, 2'd3, 64'h1122_3344_5566_7788);
        do_write(4'd3, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("half_merge", rd(0), 64'h1122_3344_5566_FFFF);
        do_write(4'd3, 2'd3, 64'h1122_3344_5566_7788);
        do_write(4'd3, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("word_merge", rd(0), 64'h1122_3344_FFFF_FFFF);

        // 3. scoreboard on r5
        set_rd(1, 4'd5);
        chk("r5_idle_busy", {63'd0, rdbusy[1]}, 64'd0);
        do_claim(4'd5);
        chk("claim_busy_c1", {63'd0, rdbusy[1]}, 64'd1);
        chk("claim_busy_vec", {48'd0, busy_vec}, 64'h0020);
        tick();
        chk("claim_busy_c2", {63'd0, rdbusy[1]}, 64'd1);
        tick();
        chk("claim_busy_c3", {63'd0, rdbusy[1]}, 64'd1);
        wr = 1'b1; wrsel = 4'd5; width = 2'd3; din = 64'h5555;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wr_edge_pre_busy", {63'd0, rdbusy[1]}, 64'd0);
        chk("wr_edge_pre_data", rd(1), 64'h5555);
`else
        chk("wr_edge_pre_busy", {63'd0, rdbusy[1]}, 64'd1);
        chk("wr_edge_pre_data", rd(1), 64'h0);
`endif
        tick();
        wr = 1'b0;
        #1;
        chk("wr_clears_busy", {63'd0, rdbusy[1]}, 64'd0);
        chk("wr_clears_vec", {48'd0, busy_vec}, 64'h0);
        chk("wr_r5_data", rd(1), 64'h5555);
        wr = 1'b1; wrsel = 4'd5; width = 2'd3; din = 64'h6666;
        claim = 1'b1; claimsel = 4'd5;
        tick();
        wr = 1'b0; claim = 1'b0;
        #1;
        chk("same_cyc_data", rd(1), 64'h6666);
        chk("same_cyc_busy", {48'd0, busy_vec}, 64'h0020);
        do_claim(4'd5);
        chk("reclaim_busy", {63'd0, rdbusy[1]}, 64'd1);
        do_write(4'd8, 2'd3, 64'h8888);
        set_rd(2, 4'd8);
        chk("nonbusy_wr_data", rd(2), 64'h8888);
        chk("nonbusy_wr_vec", {48'd0, busy_vec}, 64'h0020);

        // 4. all ports on r7, then r0 hardwired
        do_write(4'd7, 2'd3, 64'hDEAD);
        for (int p = 0; p < NRD; p++) set_rd(p, 4'd7);
        chk("p0_r7", rd(0), 64'hDEAD);
        chk("p1_r7", rd(1), 64'hDEAD);
        chk("p2_r7", rd(2), 64'hDEAD);
        chk("p3_r7", rd(3), 64'hDEAD);
        set_rd(0, 4'd0);
        wr = 1'b1; wrsel = 4'd0; width = 2'd3; din = 64'h1;
        claim = 1'b1; claimsel = 4'd0;
        #1;
        chk("r0_pre_edge", rd(0), 64'h0);
        tick();
        wr = 1'b0; claim = 1'b0;
        #1;
        chk("r0_reads_zero", rd(0), 64'h0);
        chk("r0_rdbusy", {63'd0, rdbusy[0]}, 64'd0);
        chk("r0_not_in_vec", {63'd0, busy_vec[0]}, 64'd0);

        // 5. same-cycle read of a write in flight
        do_write(4'd2, 2'd3, 64'h0123_4567_89AB_CDEF);
        set_rd(0, 4'd2);
        wr = 1'b1; wrsel = 4'd2; width = 2'd3; din = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_pre_edge", rd(0), 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("bypass_pre_edge", rd(0), 64'h0123_4567_89AB_CDEF);
`endif
        tick();
        wr = 1'b0;
        #1;
        chk("bypass_post_edge", rd(0), 64'hFFFF_FFFF_FFFF_FFFF);
        wr = 1'b1; wrsel = 4'd2; width = 2'd0; din = 64'h0;
        claim = 1'b1; claimsel = 4'd2;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_claim_busy", {63'd0, rdbusy[0]}, 64'd1);
        chk("bypass_byte_data", rd(0), 64'hFFFF_FFFF_FFFF_FF00);
`else
        chk("bypass_claim_busy", {63'd0, rdbusy[0]}, 64'd0);
        chk("bypass_byte_data", rd(0), 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        tick();
        wr = 1'b0; claim = 1'b0;
        #1;
        chk("byte_post_edge", rd(0), 64'hFFFF_FFFF_FFFF_FF00);

        // 6. reset beats a same-cycle write and claim
        do_write(4'd1, 2'd3, 64'h77);
        set_rd(3, 4'd1);
        chk("r1_before_reset", rd(3), 64'h77);
        reset = 1'b1;
        wr = 1'b1; wrsel = 4'd1; width = 2'd3; din = 64'h99;
        claim = 1'b1; claimsel = 4'd1;
        tick();
        reset = 1'b0; wr = 1'b0; claim = 1'b0;
        #1;
        chk("reset_wins_data", rd(3), 64'h0);
        chk("reset_wins_busy", {48'd0, busy_vec}, 64'h0);
        set_rd(2, 4'd7);
        chk("reset_clears_r7", rd(2), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
